// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HALT
  } state_t;

  localparam logic [2:0] AR_SIZE_WORD = 3'd2;
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         inst;
    logic                fault;
  } fifo_entry_t;

  // Width of the instruction-slot index inside one bus word (at least 1 bit).
  function automatic int slot_idx_w(input int bus_w);
    return (bus_w > 32) ? $clog2(bus_w / 32) : 1;
  endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous FIFO with combinational head read and a flush that empties it in one cycle.
module ifu_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Sequential fetch front end: one outstanding read, DEPTH-entry instruction queue, redirect flush.
// Optional access-fault reporting (r_err/out_fault, HALT state) is enabled by IFU_ACCESS_FAULT_EN.
module ifu_prefetch_queue
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              BUS_W    = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h80000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             ar_valid,
  input  logic             ar_ready,
  output logic [XLEN-1:0]  ar_addr,
  output logic [2:0]       ar_size,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [BUS_W-1:0] r_data
`ifdef IFU_ACCESS_FAULT_EN
  ,
  input  logic             r_err,
  output logic             out_fault
`endif
);

  localparam int NSLOT = BUS_W / 32;
  localparam int SW    = slot_idx_w(BUS_W);
  localparam int CW    = $clog2(DEPTH) + 1;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] ar_addr_reg, ar_addr_next;
  logic            discard_reg, discard_next;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     sel_inst;
  logic            resp_err;
  logic [XLEN-1:0] redirect_target;
  fifo_entry_t     push_entry;
  fifo_entry_t     head_entry;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IFU_ACCESS_FAULT_EN
  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

  generate
    if (NSLOT == 1) begin : g_single_slot
      assign sel_inst = r_data[31:0];
    end else begin : g_multi_slot
      logic [SW-1:0] slot;
      assign slot     = pc_reg[2 +: SW];
      assign sel_inst = r_data[32*slot +: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      ar_addr_reg <= RESET_PC;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ar_addr_reg <= ar_addr_next;
      discard_reg <= discard_next;
    end
  end

  // A redirect in REQ marks the still-pending request as stale right away;
  // the flag only takes effect on the response seen in WAIT.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ar_addr_next = ar_addr_reg;
    discard_next = discard_reg;
    push         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!redirect_valid && !fifo_full) begin
          state_next   = REQ;
          ar_addr_next = pc_reg;
        end
      end
      REQ: begin
        if (ar_ready) state_next = WAIT;
        if (redirect_valid) discard_next = 1'b1;
      end
      WAIT: begin
        if (r_valid) begin
          state_next   = IDLE;
          discard_next = 1'b0;
          if (!discard_reg && !redirect_valid) begin
            push = 1'b1;
            if (resp_err) state_next = HALT;
            else          pc_next    = pc_reg + XLEN'(4);
          end
        end else if (redirect_valid) begin
          discard_next = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect_valid) pc_next = redirect_target;
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = PC_MAX_W'(pc_reg);
    push_entry.inst  = resp_err ? 32'd0 : sel_inst;
    push_entry.fault = resp_err;
  end

  ifu_inst_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fifo_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (push_entry),
    .dout (head_entry),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_inst  = fifo_empty ? 32'd0 : head_entry.inst;
  assign out_pc    = fifo_empty ? '0 : head_entry.pc[XLEN-1:0];
`ifdef IFU_ACCESS_FAULT_EN
  assign out_fault = fifo_empty ? 1'b0 : head_entry.fault;
`endif

  assign ar_valid = (state_reg == REQ);
  assign ar_addr  = ar_addr_reg;
  assign ar_size  = AR_SIZE_WORD;
  assign r_ready  = (state_reg == WAIT);

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Self-checking bench: behavioural memory slave plus an in-order fetch-stream scoreboard.
module tb_ifu_prefetch_queue;

  localparam int          XLEN     = 64;
  localparam int          BUS_W    = 64;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h80000000;
`ifdef IFU_ACCESS_FAULT_EN
  localparam bit FAULT_ON = 1'b1;
`else
  localparam bit FAULT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [XLEN-1:0]  out_pc;
  logic             ar_valid;
  logic             ar_ready;
  logic [XLEN-1:0]  ar_addr;
  logic [2:0]       ar_size;
  logic             r_valid;
  logic             r_ready;
  logic [BUS_W-1:0] r_data;
`ifdef IFU_ACCESS_FAULT_EN
  logic             r_err;
  logic             out_fault;
`endif

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // slave controls: ar_mode 0=never ready, 1=always ready, 2=random
  int          ar_mode;
  int          r_delay_min;
  int          r_delay_max;
  bit          const_mode;
  logic [63:0] const_word;
  logic [63:0] fault_addr;
  bit          have_pend, hs_ar, hs_r;
  logic [63:0] pend_addr, ar_addr_q;
  int          pend_wait;
  logic [63:0] next_exp;

  always #5 clk = ~clk;

  ifu_prefetch_queue #(
    .XLEN(XLEN), .BUS_W(BUS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
`ifdef IFU_ACCESS_FAULT_EN
    , .r_err(r_err), .out_fault(out_fault)
`endif
  );

  // Memory image: each 32-bit word is a hash of its byte address.
  function automatic logic [31:0] mem_inst(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E3779B1;
    return h ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  function automatic logic [63:0] bus_word(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    if (const_mode) return const_word;
    return {mem_inst(base + 64'd4), mem_inst(base)};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] p);
    logic [63:0] w;
    if (FAULT_ON && p == fault_addr) return 32'd0;
    w = bus_word(p);
    return p[2] ? w[63:32] : w[31:0];
  endfunction

  // Slave: acts on negedges, one pending read, response after a random delay.
  initial begin
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    have_pend = 1'b0; hs_ar = 1'b0; hs_r = 1'b0; pend_wait = 0;
    pend_addr = '0; ar_addr_q = '0;
`ifdef IFU_ACCESS_FAULT_EN
    r_err = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_ready = 1'b0; r_valid = 1'b0; have_pend = 1'b0; hs_ar = 1'b0; hs_r = 1'b0;
      end else begin
        if (hs_r) begin
          r_valid = 1'b0;
          have_pend = 1'b0;
        end
        if (hs_ar) begin
          have_pend = 1'b1;
          pend_addr = ar_addr_q;
          pend_wait = $urandom_range(r_delay_max, r_delay_min);
        end
        if (have_pend && !r_valid) begin
          if (pend_wait == 0) begin
            r_valid = 1'b1;
            r_data  = bus_word(pend_addr);
`ifdef IFU_ACCESS_FAULT_EN
            r_err   = (pend_addr == fault_addr);
`endif
          end else begin
            pend_wait--;
          end
        end
        case (ar_mode)
          0:       ar_ready = 1'b0;
          1:       ar_ready = 1'b1;
          default: ar_ready = 1'($urandom_range(1, 0));
        endcase
        hs_ar     = ar_valid && ar_ready;
        ar_addr_q = ar_addr;
        hs_r      = r_valid && r_ready;
      end
    end
  end

  // Reference model: decode sees the sequential stream from the latest target, in order.
  initial begin
    next_exp = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        next_exp = RESET_PC;
      end else if (redirect_valid) begin
        next_exp = {redirect_pc[63:2], 2'b00};
      end else if (out_valid && out_ready) begin
        total++;
        if (out_pc !== next_exp || out_inst !== exp_inst(next_exp)) begin
          bad++;
          $display("FAIL sb_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                   out_pc, out_inst, next_exp, exp_inst(next_exp));
        end
`ifdef IFU_ACCESS_FAULT_EN
        total++;
        if (out_fault !== (next_exp == fault_addr)) begin
          bad++;
          $display("FAIL sb_fault: got %b want %b at pc=%h", out_fault, next_exp == fault_addr, next_exp);
        end
`endif
        pops++;
        next_exp = next_exp + 64'd4;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (ar_valid !== 1'b0) begin bad++; $display("FAIL reset_ar_valid: got %b want 0", ar_valid); end
    if (r_ready !== 1'b0) begin bad++; $display("FAIL reset_r_ready: got %b want 0", r_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_inst !== 32'd0) begin bad++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    if (out_pc !== 64'd0) begin bad++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    rst = 1'b0;
    $display("test_reset: reset outputs checked");
  endtask

  task automatic test_latency();
    int first_ar, first_ov, n;
    logic [63:0] addrs [3];
    bit prev;
    first_ar = -1; first_ov = -1; n = 0; prev = 1'b0;
    for (int k = 0; k < 3; k++) addrs[k] = '0;
    ar_mode = 1; r_delay_min = 0; r_delay_max = 0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ar_valid && !prev) begin
        if (n < 3) addrs[n] = ar_addr;
        n++;
        if (first_ar < 0) first_ar = i;
      end
      prev = ar_valid;
      if (out_valid && first_ov < 0) first_ov = i;
      @(posedge clk); #1;
    end
    total += 6;
    if (first_ar != 1) begin bad++; $display("FAIL lat_first_ar: got cycle %0d want 1", first_ar); end
    if (first_ov - first_ar != 2) begin bad++; $display("FAIL lat_out_valid: got %0d want 2", first_ov - first_ar); end
    if (n < 3) begin bad++; $display("FAIL lat_req_count: got %0d want >=3", n); end
    if (addrs[0] !== 64'h80000000) begin bad++; $display("FAIL lat_addr0: got %h want 80000000", addrs[0]); end
    if (addrs[1] !== 64'h80000004) begin bad++; $display("FAIL lat_addr1: got %h want 80000004", addrs[1]); end
    if (addrs[2] !== 64'h80000008) begin bad++; $display("FAIL lat_addr2: got %h want 80000008", addrs[2]); end
    $display("test_latency: first ar cycle %0d, first out_valid cycle %0d", first_ar, first_ov);
  endtask

  task automatic test_inst_select();
    int t;
    do_reset();
    const_mode = 1'b1; const_word = 64'h11111111_22222222;
    ar_mode = 1; r_delay_min = 0; r_delay_max = 0;
    for (t = 0; t < 40 && !out_valid; t++) begin @(posedge clk); #1; end
    total += 2;
    if (out_pc !== 64'h80000000) begin bad++; $display("FAIL sel_pc0: got %h want 80000000", out_pc); end
    if (out_inst !== 32'h22222222) begin bad++; $display("FAIL sel_inst0: got %h want 22222222", out_inst); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (t = 0; t < 40 && !out_valid; t++) begin @(posedge clk); #1; end
    total += 2;
    if (out_pc !== 64'h80000004) begin bad++; $display("FAIL sel_pc1: got %h want 80000004", out_pc); end
    if (out_inst !== 32'h11111111) begin bad++; $display("FAIL sel_inst1: got %h want 11111111", out_inst); end
    $display("test_inst_select: slot select checked");
  endtask

  task automatic test_full();
    int reqs;
    bit prev;
    do_reset();
    const_mode = 1'b0;
    ar_mode = 1; r_delay_min = 0; r_delay_max = 0; out_ready = 1'b0;
    reqs = 0; prev = ar_valid;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ar_valid && !prev) reqs++;
      prev = ar_valid;
    end
    total += 3;
    if (reqs != DEPTH) begin bad++; $display("FAIL full_reqs: got %0d want %0d", reqs, DEPTH); end
    if (ar_valid !== 1'b0) begin bad++; $display("FAIL full_ar_idle: got %b want 0", ar_valid); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    reqs = 0; prev = ar_valid;
    for (int i = 0; i < 20; i++) begin
      if (ar_valid && !prev) reqs++;
      prev = ar_valid;
      @(posedge clk); #1;
    end
    total++;
    if (reqs != 1) begin bad++; $display("FAIL full_refill: got %0d want 1", reqs); end
    $display("test_full: queue full behaviour checked");
  endtask

  task automatic test_redirect_wait();
    int t;
    bit early, seen_ar, prev;
    logic [63:0] new_addr, first_pc;
    do_reset();
    ar_mode = 1; r_delay_min = 3; r_delay_max = 3; out_ready = 1'b1;
    for (t = 0; t < 20 && !r_ready; t++) begin @(posedge clk); #1; end
    total++;
    if (!r_ready) begin bad++; $display("FAIL rw_wait_timeout: got r_ready=%b want 1", r_ready); end
    redirect_valid = 1'b1; redirect_pc = 64'h80001002;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_flush: got out_valid=%b want 0", out_valid); end
    early = 1'b0; seen_ar = 1'b0; prev = ar_valid; new_addr = '0; first_pc = '0;
    for (t = 0; t < 60 && !(seen_ar && out_valid); t++) begin
      if (out_valid && !seen_ar) early = 1'b1;
      if (ar_valid && !prev && !seen_ar) begin seen_ar = 1'b1; new_addr = ar_addr; end
      prev = ar_valid;
      @(posedge clk); #1;
    end
    if (out_valid) first_pc = out_pc;
    total += 3;
    if (early) begin bad++; $display("FAIL rw_stale: got stale entry want none"); end
    if (new_addr !== 64'h80001000) begin bad++; $display("FAIL rw_ar_addr: got %h want 80001000", new_addr); end
    if (first_pc !== 64'h80001000) begin bad++; $display("FAIL rw_out_pc: got %h want 80001000", first_pc); end
    r_delay_min = 0; r_delay_max = 0;
    $display("test_redirect_wait: new fetch at %h", new_addr);
  endtask

  task automatic test_redirect_req();
    int t;
    bit early, seen_ar, prev;
    logic [63:0] old_addr, new_addr, first_pc;
    do_reset();
    ar_mode = 0; r_delay_min = 0; r_delay_max = 0; out_ready = 1'b1;
    for (t = 0; t < 20 && !ar_valid; t++) begin @(posedge clk); #1; end
    old_addr = ar_addr;
    redirect_valid = 1'b1; redirect_pc = 64'h80002000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      total++;
      if (ar_valid !== 1'b1 || ar_addr !== old_addr) begin
        bad++;
        $display("FAIL rq_hold%0d: got valid=%b addr=%h want valid=1 addr=%h", i, ar_valid, ar_addr, old_addr);
      end
    end
    ar_mode = 1;
    early = 1'b0; seen_ar = 1'b0; prev = ar_valid; new_addr = '0; first_pc = '0;
    for (t = 0; t < 60 && !(seen_ar && out_valid); t++) begin
      if (out_valid && !seen_ar) early = 1'b1;
      if (ar_valid && !prev && !seen_ar) begin seen_ar = 1'b1; new_addr = ar_addr; end
      prev = ar_valid;
      @(posedge clk); #1;
    end
    if (out_valid) first_pc = out_pc;
    total += 3;
    if (early) begin bad++; $display("FAIL rq_stale: got stale entry want none"); end
    if (new_addr !== 64'h80002000) begin bad++; $display("FAIL rq_ar_addr: got %h want 80002000", new_addr); end
    if (first_pc !== 64'h80002000) begin bad++; $display("FAIL rq_out_pc: got %h want 80002000", first_pc); end
    $display("test_redirect_req: old addr %h held, new fetch at %h", old_addr, new_addr);
  endtask

`ifdef IFU_ACCESS_FAULT_EN
  task automatic test_fault();
    int t, reqs;
    bit seen, prev;
    logic [63:0] new_addr;
    do_reset();
    fault_addr = 64'h80000010;
    ar_mode = 1; r_delay_min = 0; r_delay_max = 0; out_ready = 1'b1;
    seen = 1'b0;
    for (t = 0; t < 80 && !seen; t++) begin
      @(posedge clk); #1;
      if (out_valid && out_pc == 64'h80000010) begin
        seen = 1'b1;
        total += 2;
        if (out_fault !== 1'b1) begin bad++; $display("FAIL flt_flag: got %b want 1", out_fault); end
        if (out_inst !== 32'd0) begin bad++; $display("FAIL flt_inst: got %h want 0", out_inst); end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL flt_seen: got no faulting entry want one"); end
    reqs = 0; prev = ar_valid;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ar_valid && !prev) reqs++;
      prev = ar_valid;
    end
    total++;
    if (reqs != 0) begin bad++; $display("FAIL flt_halt: got %0d requests want 0", reqs); end
    redirect_valid = 1'b1; redirect_pc = 64'h80000100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    new_addr = '0;
    for (t = 0; t < 20 && !ar_valid; t++) begin @(posedge clk); #1; end
    if (ar_valid) new_addr = ar_addr;
    total++;
    if (new_addr !== 64'h80000100) begin bad++; $display("FAIL flt_resume: got %h want 80000100", new_addr); end
    $display("test_fault: halt and resume checked");
  endtask
`endif

  task automatic test_random();
    int start_pops;
    do_reset();
    fault_addr = '1;
    ar_mode = 2; r_delay_min = 0; r_delay_max = 3;
    start_pops = pops;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(1, 0));
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc = 64'h80000000 + 64'($urandom_range(4095, 0));
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    total++;
    if (pops - start_pops < 50) begin bad++; $display("FAIL rnd_progress: got %0d pops want >=50", pops - start_pops); end
    $display("test_random: %0d pops checked", pops - start_pops);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    ar_mode = 1; r_delay_min = 0; r_delay_max = 0;
    const_mode = 1'b0; const_word = '0; fault_addr = '1;
    test_reset();
    test_latency();
    test_inst_select();
    test_full();
    test_redirect_wait();
    test_redirect_req();
`ifdef IFU_ACCESS_FAULT_EN
    test_fault();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch_queue.md
Name: ifu_prefetch_queue

Overview:
- Parametrised instruction-fetch front end. Issues sequential PC reads over an AXI-style read-address/read-data handshake and buffers returned instructions in a DEPTH-entry FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Handles redirects (jal/jalr/branch/trap) by flushing the queue and discarding any in-flight response. This replaces the single-register fetch with forced-update/delay flags.

Parameters:
- XLEN, 64, address/PC width.
- BUS_W, 64, read-data width; must be a power of 2, ≥32; holds BUS_W/32 instruction slots.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- RESET_PC, 64'h80000000, PC loaded on reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- redirect_valid  in  1  redirect request from the memory/trap stage.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0 internally.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_inst  out  32  head instruction; 0 when empty.
- out_pc  out  XLEN  head PC; 0 when empty.
- ar_valid  out  1  read-address valid.
- ar_ready  in  1  read-address accepted.
- ar_addr  out  XLEN  fetch PC.
- ar_size  out  3  fixed 3'd2 (4 bytes).
- r_valid  in  1  read data valid.
- r_ready  out  1  ready for read data.
- r_data  in  BUS_W  bus word containing the instruction.

Behaviour:
- Reset values: pc=RESET_PC; FSM in IDLE; count=0; discard=0; ar_valid=0; r_ready=0; out_valid=0; out_inst=0; out_pc=0.
- FSM states and transitions:
  - IDLE → REQ when count<DEPTH and no redirect this cycle. This is the one-outstanding rule, and it guarantees a free slot when the response arrives.
  - REQ: ar_valid=1, ar_addr=pc; ar_addr is held stable until ar_ready. On handshake → WAIT.
  - WAIT: r_ready=1. On r_valid → IDLE.
    - If discard=0: push {inst, pc}, then pc<=pc+4.
    - If discard=1: drop the data, clear discard, leave pc unchanged.
- Instruction select: inst = r_data[32*k +: 32], where k = pc[log2(BUS_W/8)-1:2]. When BUS_W=32, k=0.
- Output side:
  - out_valid = (count!=0); out_inst/out_pc come from the head entry, combinationally.
  - A pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect has highest priority:
  - Flush the FIFO (count=0, pointers reset) and set pc<=redirect_pc with [1:0]=0.
  - In REQ: ar_valid stays asserted with the old address until handshake, then discard=1.
  - In WAIT: discard=1; if r_valid arrives in the redirect cycle, the data is dropped and discard stays 0.
  - In IDLE: no request is issued that cycle.
  - A push or pop coinciding with a redirect is overridden by the flush.
  - Back-to-back redirects: the last one wins; at most one response is ever discarded.
- Latency and throughput:
  - With ar_ready=1 and r_valid one cycle later: ar_valid in cycle T, push at end of T+1, out_valid in T+2.
  - Steady state is one instruction per 3 cycles (IDLE/REQ/WAIT).
- PC arithmetic wraps modulo 2^XLEN.
- Full FIFO: no issue; fetch resumes in the cycle after a pop makes count<DEPTH.

Optional Feature:
- Macro IFU_ACCESS_FAULT_EN.
- When defined:
  - Adds input r_err (1) and output out_fault (1).
  - A non-discarded response with r_err=1 pushes an entry with fault=1 and inst=0, then holds the FSM in a HALT state (no further issue) until redirect.
  - out_fault is 0 when empty or at reset.
- When undefined: neither port exists, there is no HALT state, and every response is treated as OK.

Decomposition:
- Package ifu_pkg holds:
  - FSM state enum (IDLE, REQ, WAIT, HALT).
  - AR_SIZE_WORD=3'd2.
  - Fifo-entry struct {pc, inst, fault}.
  - Slot-index width function.
- One sub-module, ifu_inst_fifo: synchronous FIFO parametrised on DEPTH and entry width, with push, pop, flush, count, full and empty.

Test Plan:
- Reset then always-ready slave, one-cycle data: ar_addr=0x80000000, 0x80000004, 0x80000008 in order; out_pc follows the same sequence, with the first out_valid 2 cycles after the first ar_valid.
- BUS_W=64, r_data=0x11111111_22222222: at pc 0x80000000 out_inst=0x22222222; at pc 0x80000004 out_inst=0x11111111.
- out_ready=0 and DEPTH=4: exactly 4 requests issued, then ar_valid stays 0. Pulse out_ready once and exactly one new request follows.
- Redirect to 0x80001002 while in WAIT: the stale response is dropped and the FIFO is empty. The next ar_addr is 0x80001000 and the first out_pc is 0x80001000.
- Redirect while in REQ with ar_ready held low for 3 cycles: the old ar_addr stays stable until handshake. Its response is discarded, then the new PC is fetched.
- With IFU_ACCESS_FAULT_EN, r_err=1 at 0x80000010: out_fault=1, out_inst=0, and no further ar_valid until a redirect to 0x80000100 resumes fetch.
